// File: rtl/fa_divisor.sv
// rtl/fa_divisor.sv - multi-cycle restoring unsigned divider built on a full-adder ripple chain
// One quotient bit per clock; start/done handshake, results held until the next start.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module fa_divisor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             done,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH-1:0] dvs_n;
  logic [WIDTH-1:0] trial;
  logic [WIDTH:0]   carry;
  logic             no_borrow;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] prem_next;

  assign prem_sh  = {prem, q[WIDTH-1]};
  assign dvs_n    = ~dvs;
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    fa_cell u_fa (
      .a  (prem_sh[gi]),
      .b  (dvs_n[gi]),
      .ci (carry[gi]),
      .s  (trial[gi]),
      .co (carry[gi+1])
    );
  end

  // Top cell of the WIDTH+1 chain: divisor bit is a constant 0 (inverted to 1), so only its carry matters.
  assign no_borrow = prem_sh[WIDTH] | carry[WIDTH];
  assign q_next    = {q[WIDTH-2:0], no_borrow};
  assign prem_next = no_borrow ? trial : prem_sh[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      q     <= '0;
      prem  <= '0;
      dvs   <= '0;
      Res   <= '0;
      Rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (B == '0) begin
              Res  <= '1;
              Rem  <= A;
              dbz  <= 1'b1;
              done <= 1'b1;
            end else begin
              q     <= A;
              dvs   <= B;
              prem  <= '0;
              count <= ITERS;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          q     <= q_next;
          prem  <= prem_next;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            Res   <= q_next;
            Rem   <= prem_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            dbz   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fa_divisor.sv
// tb/tb_fa_divisor.sv - directed self-checking bench for fa_divisor (WIDTH=32)

module tb_fa_divisor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Res, Rem;
  logic        busy, done, dbz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fa_divisor #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Res   (Res),
    .Rem   (Rem),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one operation at a negedge and follows it to done; optional mid-run start injection.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [31:0] exp_rem,
                         input logic exp_dbz, input int exp_lat, input int exp_busy,
                         input int inj_at, input logic [31:0] ia, input logic [31:0] ib);
    int n = 0;
    int busy_cycles = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (inj_at != 0 && n == inj_at) begin
        A = ia; B = ib; start = 1'b1;
      end
      if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) break;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check({tag, "_res"}, Res, exp_res);
    check({tag, "_rem"}, Rem, exp_rem);
    check({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_res_hold"}, Res, exp_res);
  endtask

  initial begin
    int n;
    int pulses;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_res", Res, 32'd0);
    check("reset_rem", Rem, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(dbz), 32'd0);

    run_div("d4_2", 32'd4, 32'd2, 32'd2, 32'd0, 1'b0, 33, 32, 0, 0, 0);
    run_div("d7_2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, 32, 0, 0, 0);
    run_div("d3_5", 32'd3, 32'd5, 32'd0, 32'd3, 1'b0, 33, 32, 0, 0, 0);
    run_div("dmax_1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33, 32, 0, 0, 0);
    run_div("d0_0", 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 0, 0, 0, 0);
    run_div("d7_0", 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 1'b1, 1, 0, 0, 0, 0);
    run_div("d100_7_inj", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, 5, 32'd9, 32'd3);

    // Abort at iteration 10 with reset; no done may follow.
    @(negedge clk);
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_res", Res, 32'd0);
    check("abort_rem", Rem, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 32, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
